// File: rtl/avr_xbus_pkg.sv
// Shared definitions for the AVR-style multiplexed external-bus master.
package avr_xbus_pkg;

    // Width of the per-phase cycle counter; phases last 1..15 clocks.
    localparam int XB_CNT_W = 4;

    // Default value driven on the AD pads when neither address nor data is out.
    localparam logic [7:0] XB_IDLE_VALUE = 8'h00;

    // Bus cycle phases, in the order a transfer walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALE    = 3'd1,
        ST_AHOLD  = 3'd2,
        ST_STROBE = 3'd3,
        ST_END    = 3'd4
    } xb_state_t;

endpackage

// File: rtl/avr_xbus_master.sv
// AVR-style multiplexed external-memory bus initiator.
// A req/done handshake from internal logic becomes a full ALE / address-hold /
// strobe / end bus cycle. Every output is a flop; the next-value logic looks
// one state ahead so each output lines up with the phase it belongs to.
module avr_xbus_master
    import avr_xbus_pkg::*;
#(
    parameter int         ALE_CYCLES    = 1,
    parameter int         STROBE_CYCLES = 2,
    parameter logic [7:0] IDLE_VALUE    = XB_IDLE_VALUE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic [7:0]  a,
    output logic        ale,
    output logic        wd,
    output logic        rd
);

    // Out-of-range phase lengths cannot be represented by the 4-bit counter.
    if (ALE_CYCLES < 1 || ALE_CYCLES > 15) begin : g_bad_ale_cycles
        $error("avr_xbus_master: ALE_CYCLES must be within 1..15");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe_cycles
        $error("avr_xbus_master: STROBE_CYCLES must be within 1..15");
    end

    // Counter reload values: a phase of N clocks counts N-1 down to 0.
    localparam logic [XB_CNT_W-1:0] LP_ALE_LOAD    = XB_CNT_W'(ALE_CYCLES - 1);
    localparam logic [XB_CNT_W-1:0] LP_STROBE_LOAD = XB_CNT_W'(STROBE_CYCLES - 1);

    xb_state_t             r_state;
    logic [XB_CNT_W-1:0]   r_cnt;

    // Transfer parameters frozen at acceptance.
    logic                  r_we;
    logic [7:0]            r_addr_lo;
    logic [7:0]            r_wdata;

    // Registered outputs.
    logic                  r_ale;
    logic                  r_wd;
    logic                  r_rd;
    logic                  r_oe;
    logic [7:0]            r_ad;
    logic [7:0]            r_a;
    logic                  r_busy;
    logic                  r_done;
    logic [7:0]            r_rdata;

    // Next-state / next-output values.
    xb_state_t             w_state_nx;
    logic [XB_CNT_W-1:0]   w_cnt_nx;
    logic                  w_capture;
    logic                  w_rd_capture;
    logic                  w_ale_nx;
    logic                  w_wd_nx;
    logic                  w_rd_nx;
    logic                  w_oe_nx;
    logic [7:0]            w_ad_nx;
    logic [7:0]            w_a_nx;
    logic                  w_busy_nx;
    logic                  w_done_nx;

    // Next-state decode and the output values for the phase being entered.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_capture    = 1'b0;
        w_rd_capture = 1'b0;
        w_ale_nx     = 1'b0;
        w_wd_nx      = 1'b1;
        w_rd_nx      = 1'b1;
        w_oe_nx      = 1'b0;
        w_ad_nx      = IDLE_VALUE;
        w_a_nx       = r_a;
        w_busy_nx    = 1'b1;
        w_done_nx    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nx = 1'b0;
                if (req) begin
                    // Address comes straight from the inputs: the capture
                    // registers load on this same edge.
                    w_state_nx = ST_ALE;
                    w_cnt_nx   = LP_ALE_LOAD;
                    w_capture  = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_ale_nx   = 1'b1;
                    w_oe_nx    = 1'b1;
                    w_ad_nx    = addr[7:0];
                    w_a_nx     = addr[15:8];
                end
            end

            ST_ALE: begin
                w_oe_nx = 1'b1;
                w_ad_nx = r_addr_lo;
                if (r_cnt == '0) begin
                    // Drop ALE but keep the address on AD for hold time.
                    w_state_nx = ST_AHOLD;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                    w_ale_nx = 1'b1;
                end
            end

            ST_AHOLD: begin
                w_state_nx = ST_STROBE;
                w_cnt_nx   = LP_STROBE_LOAD;
                if (r_we) begin
                    w_oe_nx = 1'b1;
                    w_ad_nx = r_wdata;
                    w_wd_nx = 1'b0;
                end else begin
                    w_rd_nx = 1'b0;
                end
            end

            ST_STROBE: begin
                if (r_cnt == '0) begin
                    // Strobe releases; write data stays driven for hold,
                    // reads leave the pads tristated as turnaround.
                    w_state_nx   = ST_END;
                    w_done_nx    = 1'b1;
                    w_rd_capture = ~r_we;
                    if (r_we) begin
                        w_oe_nx = 1'b1;
                        w_ad_nx = r_wdata;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                    if (r_we) begin
                        w_oe_nx = 1'b1;
                        w_ad_nx = r_wdata;
                        w_wd_nx = 1'b0;
                    end else begin
                        w_rd_nx = 1'b0;
                    end
                end
            end

            ST_END: begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State, phase counter and all registered outputs; reset returns the bus to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ale   <= 1'b0;
            r_wd    <= 1'b1;
            r_rd    <= 1'b1;
            r_oe    <= 1'b0;
            r_ad    <= IDLE_VALUE;
            r_a     <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ale   <= w_ale_nx;
            r_wd    <= w_wd_nx;
            r_rd    <= w_rd_nx;
            r_oe    <= w_oe_nx;
            r_ad    <= w_ad_nx;
            r_a     <= w_a_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            if (w_rd_capture) begin
                r_rdata <= ad_in;
            end
        end
    end

    // Request capture; only loads on acceptance so values stay frozen all transfer.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_we      <= we;
            r_addr_lo <= addr[7:0];
            r_wdata   <= wdata;
        end
    end

    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ad_out = r_ad;
    assign ad_oe  = r_oe;
    assign a      = r_a;
    assign ale    = r_ale;
    assign wd     = r_wd;
    assign rd     = r_rd;

endmodule
